timer_bank: RTL and testbench

- Multi-channel, parametrised successor to the single 12-bit game-timing counter.
- NUM_CH independent up-counters share one prescaler on clk_2K.
- Each channel has a runtime-programmable terminal value and a one-shot/auto-reload mode, with clear-acknowledge, done-level and expiry-pulse outputs.
- Sits between the global FSM and the display/timeout logic; replaces per-use counter instances (2 s reveal delay, dealer pacing, idle timeout).

---
 rtl/timer_bank.sv | 98 +++++++++
 tb/tb_timer_bank.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   A bank of NUM_CH independent up-counters. All channels share one free-running
//   prescaler on clk_2K. Each channel has a runtime terminal value and a
//   one-shot (saturate) or auto-reload (wrap to 0) mode.
//
// Ports
//   clk_2K      : 2 kHz system clock
//   i_Reset_n   : asynchronous active-low reset
//   i_En        : per-channel count enable
//   i_Clr       : per-channel synchronous clear (wins over enable)
//   i_Mode      : per-channel mode, 0 = one-shot, 1 = auto-reload
//   i_Limit     : packed terminal values, channel k at [k*WIDTH +: WIDTH]
//   o_Count     : packed registered counts, same packing as i_Limit
//   o_Done      : combinational, channel enabled, not clearing, count >= limit
//   o_ExpPulse  : registered one-cycle pulse when an advance lands on the limit
//   o_ClrOK     : registered clear acknowledge, one cycle per sampled clear
// -----------------------------------------------------------------------------
module timer_bank #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned PRESC_DIV = 1
) (
    input  logic                    clk_2K,
    input  logic                    i_Reset_n,
    input  logic [NUM_CH-1:0]       i_En,
    input  logic [NUM_CH-1:0]       i_Clr,
    input  logic [NUM_CH-1:0]       i_Mode,
    input  logic [NUM_CH*WIDTH-1:0] i_Limit,
    output logic [NUM_CH*WIDTH-1:0] o_Count,
    output logic [NUM_CH-1:0]       o_Done,
    output logic [NUM_CH-1:0]       o_ExpPulse,
    output logic [NUM_CH-1:0]       o_ClrOK
);

    // At least one bit so PRESC_DIV=1 still yields a legal (constant 0) register.
    localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] r_Presc;
    logic          tick;

    assign tick = (r_Presc == PRESC_LAST);

    // Free-running; channel clears deliberately do not realign it.
    always_ff @(posedge clk_2K or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Presc <= '0;
        end else if (tick) begin
            r_Presc <= '0;
        end else begin
            r_Presc <= r_Presc + PW'(1);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WIDTH-1:0] r_Cnt;
        logic [WIDTH-1:0] lim;
        logic             r_Exp;
        logic             r_ClrOK;

        assign lim = i_Limit[k*WIDTH +: WIDTH];

        always_ff @(posedge clk_2K or negedge i_Reset_n) begin
            if (!i_Reset_n) begin
                r_Cnt   <= '0;
                r_Exp   <= 1'b0;
                r_ClrOK <= 1'b0;
            end else begin
                r_ClrOK <= i_Clr[k];
                if (i_Clr[k]) begin
                    r_Cnt <= '0;
                    r_Exp <= 1'b0;
                end else if (i_En[k] && tick) begin
                    if (r_Cnt < lim) begin
                        // cnt < lim guarantees the increment cannot overflow.
                        r_Cnt <= r_Cnt + WIDTH'(1);
                        r_Exp <= ((r_Cnt + WIDTH'(1)) == lim);
                    end else if (i_Mode[k]) begin
                        // Wrap only pulses when the new count 0 equals the limit.
                        r_Cnt <= '0;
                        r_Exp <= (lim == '0);
                    end else begin
                        r_Exp <= 1'b0;
                    end
                end else begin
                    r_Exp <= 1'b0;
                end
            end
        end

        assign o_Count[k*WIDTH +: WIDTH] = r_Cnt;
        assign o_ExpPulse[k]             = r_Exp;
        assign o_ClrOK[k]                = r_ClrOK;
        assign o_Done[k]                 = i_En[k] && !i_Clr[k] && (r_Cnt >= lim);
    end

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

    localparam int NCH = 4;
    localparam int W   = 12;

    logic              clk_2K = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    en, clr, mode;
    logic [NCH*W-1:0]  lim;

    logic [NCH*W-1:0]  cnt1, cnt3;
    logic [NCH-1:0]    done1, exp1, ok1, done3, exp3, ok3;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk_2K = ~clk_2K;

    timer_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESC_DIV(1)) u_dut1 (
        .clk_2K(clk_2K), .i_Reset_n(rst_n), .i_En(en), .i_Clr(clr), .i_Mode(mode),
        .i_Limit(lim), .o_Count(cnt1), .o_Done(done1), .o_ExpPulse(exp1), .o_ClrOK(ok1)
    );

    timer_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESC_DIV(3)) u_dut3 (
        .clk_2K(clk_2K), .i_Reset_n(rst_n), .i_En(en), .i_Clr(clr), .i_Mode(mode),
        .i_Limit(lim), .o_Count(cnt3), .o_Done(done3), .o_ExpPulse(exp3), .o_ClrOK(ok3)
    );

    // Scoreboard entry: expected registered outputs of both instances after an edge.
    typedef struct {
        logic [NCH*W-1:0] c1;
        logic [NCH-1:0]   e1, k1;
        logic [NCH*W-1:0] c3;
        logic [NCH-1:0]   e3, k3;
    } sb_t;

    sb_t q[$];
    sb_t e;

    // Reference state: index 0 = PRESC_DIV 1, index 1 = PRESC_DIV 3.
    logic [W-1:0] mCnt [2][NCH];
    logic         mExp [2][NCH];
    logic         mOk  [2][NCH];
    int           mPresc [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mPresc[d] = 0;
            for (int k = 0; k < NCH; k++) begin
                mCnt[d][k] = '0; mExp[d][k] = 1'b0; mOk[d][k] = 1'b0;
            end
        end
        q.delete();
    endtask

    function automatic logic [NCH-1:0] mDone(int d);
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++)
            r[k] = en[k] && !clr[k] && (mCnt[d][k] >= lim[k*W +: W]);
        return r;
    endfunction

    // Push expectations for the coming edge, then advance to just after it.
    task automatic cyc();
        sb_t    s;
        bit     tk;
        logic [W-1:0] l;
        for (int d = 0; d < 2; d++) begin
            tk = (mPresc[d] == ((d == 0) ? 0 : 2));
            for (int k = 0; k < NCH; k++) begin
                l = lim[k*W +: W];
                mOk[d][k]  = clr[k];
                mExp[d][k] = 1'b0;
                if (clr[k]) begin
                    mCnt[d][k] = '0;
                end else if (en[k] && tk) begin
                    if (mCnt[d][k] < l) begin
                        mCnt[d][k] = mCnt[d][k] + 1'b1;
                        mExp[d][k] = (mCnt[d][k] == l);
                    end else if (mode[k]) begin
                        mCnt[d][k] = '0;
                        mExp[d][k] = (l == 0);
                    end
                end
            end
            mPresc[d] = tk ? 0 : mPresc[d] + 1;
        end
        for (int k = 0; k < NCH; k++) begin
            s.c1[k*W +: W] = mCnt[0][k]; s.e1[k] = mExp[0][k]; s.k1[k] = mOk[0][k];
            s.c3[k*W +: W] = mCnt[1][k]; s.e3[k] = mExp[1][k]; s.k3[k] = mOk[1][k];
        end
        q.push_back(s);
        @(posedge clk_2K);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '1; clr = '0; mode = '0; lim = {NCH{12'd100}};
        model_reset();
        repeat (5) @(posedge clk_2K);
        #1;
        nChecks++;
        if (cnt1 !== '0 || exp1 !== '0 || ok1 !== '0 || cnt3 !== '0) begin
            nErrors++;
            $display("FAIL reset_hold cnt1=%h exp1=%b ok1=%b cnt3=%h want all 0", cnt1, exp1, ok1, cnt3);
        end
        @(negedge clk_2K);
        rst_n = 1'b1;
        lim[1*W +: W] = 12'd3;
        for (int i = 1; i <= 3; i++) begin
            clr = (i == 3) ? 4'b0001 : 4'b0000;
            #1;
            nChecks++;
            if (done1 !== mDone(0)) begin
                nErrors++; $display("FAIL reset_done got=%b want=%b", done1, mDone(0));
            end
            cyc();
            e = q.pop_front();
            nChecks++;
            if (cnt1 !== e.c1 || exp1 !== e.e1 || ok1 !== e.k1) begin
                nErrors++;
                $display("FAIL reset_sb cnt=%h exp=%b ok=%b want cnt=%h exp=%b ok=%b", cnt1, exp1, ok1, e.c1, e.e1, e.k1);
            end
            nChecks++;
            if (cnt1[1*W +: W] !== 12'(i)) begin
                nErrors++; $display("FAIL reset_resume ch1=%0d want=%0d", cnt1[1*W +: W], i);
            end
        end
        // Pending pulse and acknowledge are live now; reset mid-cycle must kill them.
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (cnt1 !== '0 || exp1 !== '0 || ok1 !== '0 || cnt3 !== '0 || ok3 !== '0) begin
            nErrors++;
            $display("FAIL reset_async cnt1=%h exp1=%b ok1=%b cnt3=%h ok3=%b want all 0", cnt1, exp1, ok1, cnt3, ok3);
        end
        @(posedge clk_2K);
        @(negedge clk_2K);
        rst_n = 1'b1;
        clr = '0; en = '0; lim = {NCH{12'd100}};
        model_reset();
    endtask

    task automatic test_oneshot();
        int pulses = 0;
        en = 4'b0001; mode = '0; clr = '0; lim[0 +: W] = 12'd4000;
        for (int i = 1; i <= 4100; i++) begin
            #1;
            nChecks++;
            if (done1 !== mDone(0)) begin
                nErrors++; $display("FAIL oneshot_done i=%0d got=%b want=%b", i, done1, mDone(0));
            end
            cyc();
            e = q.pop_front();
            nChecks++;
            if (cnt1 !== e.c1 || exp1 !== e.e1 || ok1 !== e.k1) begin
                nErrors++;
                $display("FAIL oneshot_sb i=%0d cnt=%h exp=%b ok=%b want cnt=%h exp=%b ok=%b", i, cnt1, exp1, ok1, e.c1, e.e1, e.k1);
            end
            if (exp1[0]) pulses++;
            if (i == 4000) begin
                nChecks++;
                if (cnt1[0 +: W] !== 12'd4000 || exp1[0] !== 1'b1) begin
                    nErrors++; $display("FAIL oneshot_reach ch0=%0d exp=%b want 4000 1", cnt1[0 +: W], exp1[0]);
                end
            end
        end
        nChecks++;
        if (pulses != 1) begin
            nErrors++; $display("FAIL oneshot_pulses got=%0d want=1", pulses);
        end
        nChecks++;
        if (cnt1[0 +: W] !== 12'd4000 || done1[0] !== 1'b1) begin
            nErrors++; $display("FAIL oneshot_hold ch0=%0d done=%b want 4000 1", cnt1[0 +: W], done1[0]);
        end
    endtask

    task automatic test_reload();
        int pulses = 0;
        int changes = 0;
        logic [W-1:0] prev;
        clr = 4'b0010;
        #1; cyc(); e = q.pop_front();
        clr = '0; en = 4'b0011; mode = 4'b0010; lim[1*W +: W] = 12'd2;
        prev = cnt3[1*W +: W];
        for (int i = 1; i <= 27; i++) begin
            #1;
            nChecks++;
            if (done3 !== mDone(1)) begin
                nErrors++; $display("FAIL reload_done i=%0d got=%b want=%b", i, done3, mDone(1));
            end
            cyc();
            e = q.pop_front();
            nChecks++;
            if (cnt3 !== e.c3 || exp3 !== e.e3 || ok3 !== e.k3 || cnt1 !== e.c1 || exp1 !== e.e1) begin
                nErrors++;
                $display("FAIL reload_sb i=%0d cnt3=%h exp3=%b cnt1=%h exp1=%b want cnt3=%h exp3=%b cnt1=%h exp1=%b",
                         i, cnt3, exp3, cnt1, exp1, e.c3, e.e3, e.c1, e.e1);
            end
            if (exp3[1]) begin
                pulses++;
                nChecks++;
                if (cnt3[1*W +: W] !== 12'd2) begin
                    nErrors++; $display("FAIL reload_pulse_at ch1=%0d want=2", cnt3[1*W +: W]);
                end
            end
            if (cnt3[1*W +: W] !== prev) changes++;
            prev = cnt3[1*W +: W];
        end
        nChecks++;
        if (pulses != 3 || changes != 9) begin
            nErrors++; $display("FAIL reload_rate pulses=%0d changes=%0d want 3 9", pulses, changes);
        end
    endtask

    task automatic test_clear();
        clr = 4'b0100;
        #1; cyc(); e = q.pop_front();
        clr = '0; en = 4'b0111; mode[2] = 1'b0; lim[2*W +: W] = 12'd100;
        repeat (7) begin
            #1; cyc(); e = q.pop_front();
        end
        nChecks++;
        if (cnt1[2*W +: W] !== 12'd7) begin
            nErrors++; $display("FAIL clear_pre ch2=%0d want=7", cnt1[2*W +: W]);
        end
        for (int i = 0; i < 3; i++) begin
            clr = (i < 2) ? 4'b0100 : 4'b0000;
            #1;
            nChecks++;
            if (done1[2] !== 1'b0 || done1 !== mDone(0)) begin
                nErrors++; $display("FAIL clear_done i=%0d got=%b want=%b", i, done1, mDone(0));
            end
            cyc();
            e = q.pop_front();
            nChecks++;
            if (cnt1 !== e.c1 || exp1 !== e.e1 || ok1 !== e.k1) begin
                nErrors++;
                $display("FAIL clear_sb i=%0d cnt=%h exp=%b ok=%b want cnt=%h exp=%b ok=%b", i, cnt1, exp1, ok1, e.c1, e.e1, e.k1);
            end
            nChecks++;
            if (ok1[2] !== (i < 2) || cnt1[2*W +: W] !== ((i < 2) ? 12'd0 : 12'd1)) begin
                nErrors++; $display("FAIL clear_ack i=%0d ok=%b ch2=%0d want ok=%b ch2=%0d",
                                    i, ok1[2], cnt1[2*W +: W], (i < 2), (i < 2) ? 0 : 1);
            end
        end
    endtask

    task automatic test_limits();
        clr = 4'b1000;
        #1; cyc(); e = q.pop_front();
        clr = '0; en = 4'b1111; mode[3] = 1'b0; lim[3*W +: W] = 12'd100;
        repeat (10) begin
            #1; cyc(); e = q.pop_front();
        end
        nChecks++;
        if (cnt1[3*W +: W] !== 12'd10) begin
            nErrors++; $display("FAIL limits_pre ch3=%0d want=10", cnt1[3*W +: W]);
        end
        // phase 0: lim 5 one-shot; 1: lim 5 reload; 2: lim 0 reload; 3: lim 0 one-shot
        for (int i = 0; i < 16; i++) begin
            if (i == 0)  begin lim[3*W +: W] = 12'd5; mode[3] = 1'b0; end
            if (i == 5)  mode[3] = 1'b1;
            if (i == 6)  lim[3*W +: W] = 12'd0;
            if (i == 11) mode[3] = 1'b0;
            #1;
            nChecks++;
            if (done1 !== mDone(0) || done1[3] !== 1'b1) begin
                nErrors++; $display("FAIL limits_done i=%0d got=%b want=%b", i, done1, mDone(0));
            end
            cyc();
            e = q.pop_front();
            nChecks++;
            if (cnt1 !== e.c1 || exp1 !== e.e1 || ok1 !== e.k1) begin
                nErrors++;
                $display("FAIL limits_sb i=%0d cnt=%h exp=%b ok=%b want cnt=%h exp=%b ok=%b", i, cnt1, exp1, ok1, e.c1, e.e1, e.k1);
            end
            nChecks++;
            if (cnt1[3*W +: W] !== ((i < 5) ? 12'd10 : 12'd0) || exp1[3] !== (i >= 6 && i < 11)) begin
                nErrors++; $display("FAIL limits_ch3 i=%0d ch3=%0d exp=%b want ch3=%0d exp=%b",
                                    i, cnt1[3*W +: W], exp1[3], (i < 5) ? 10 : 0, (i >= 6 && i < 11));
            end
        end
    endtask

    task automatic test_max();
        int pulses = 0;
        clr = 4'b1000;
        #1; cyc(); e = q.pop_front();
        clr = '0; en = 4'b1000; mode[3] = 1'b0; lim[3*W +: W] = 12'd4095;
        for (int i = 1; i <= 4100; i++) begin
            #1; cyc();
            e = q.pop_front();
            nChecks++;
            if (cnt1 !== e.c1 || exp1 !== e.e1 || ok1 !== e.k1) begin
                nErrors++;
                $display("FAIL max_sb i=%0d cnt=%h exp=%b ok=%b want cnt=%h exp=%b ok=%b", i, cnt1, exp1, ok1, e.c1, e.e1, e.k1);
            end
            if (exp1[3]) pulses++;
        end
        nChecks++;
        if (cnt1[3*W +: W] !== 12'd4095 || done1[3] !== 1'b1 || pulses != 1) begin
            nErrors++; $display("FAIL max_sat ch3=%0d done=%b pulses=%0d want 4095 1 1", cnt1[3*W +: W], done1[3], pulses);
        end
        mode[3] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1; cyc();
            e = q.pop_front();
            nChecks++;
            if (cnt1[3*W +: W] !== 12'(i) || exp1[3] !== 1'b0 || cnt1 !== e.c1) begin
                nErrors++; $display("FAIL max_wrap i=%0d ch3=%0d exp=%b want ch3=%0d exp=0", i, cnt1[3*W +: W], exp1[3], i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_clear();
        test_limits();
        test_max();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
